// File: rtl/toggle_event_decoder.sv
// Purpose : receive side of a toggle-encoded event line; recovers one event per
//           level change and queues it in a saturating pending counter.
// Latency : Toggle_in change -> Ev_count update on edge SYNC_STAGES+1
//           (SYNC_STAGES+FILTER_CYCLES+1 with TOGGLE_DEC_FILTER_EN defined).
// Backpr. : consumer pops one event per cycle via Ev_valid/Ev_ready; events
//           arriving at a full counter are dropped and flagged on Overflow.
//
// Optional feature macro: TOGGLE_DEC_FILTER_EN (level-stability filter).
//
// Ports:
//   Clock        rising-edge clock
//   Reset        synchronous, active-low reset (highest priority)
//   Set          synchronous, aligns the receiver to encoder level 1
//   Toggle_in    toggle line, asynchronous to Clock
//   Ev_ready     consumer accepts one event this cycle
//   Ev_valid     at least one event pending (registered)
//   Ev_count     number of pending events
//   Level_out    last accepted reference level
//   Overflow     sticky dropped-event flag
//   Overflow_clr clears Overflow (a same-cycle overflow wins)
module toggle_event_decoder #(
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_W         = 3,
  parameter int FILTER_CYCLES = 3
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Set,
  input  logic             Toggle_in,
  input  logic             Ev_ready,
  output logic             Ev_valid,
  output logic [CNT_W-1:0] Ev_count,
  output logic             Level_out,
  output logic             Overflow,
  input  logic             Overflow_clr
);

  // Elaboration-time range checks on the configuration.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("toggle_event_decoder: SYNC_STAGES out of range 2..4");
  end
  if (FILTER_CYCLES < 1 || FILTER_CYCLES > 15) begin : g_bad_filt
    $error("toggle_event_decoder: FILTER_CYCLES out of range 1..15");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ref_q, ref_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;

  logic sync_lvl;
  logic edge_acc;
  logic pop;
  logic ovf_set;

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign sync_d   = {sync_q[SYNC_STAGES-2:0], Toggle_in};

`ifdef TOGGLE_DEC_FILTER_EN
  // The synchronized level must differ from the reference for FILTER_CYCLES
  // consecutive cycles before it is accepted; an earlier revert clears it.
  logic [3:0] filt_q, filt_d;

  assign edge_acc = (sync_lvl != ref_q) && (filt_q == 4'(FILTER_CYCLES));

  always_comb begin
    filt_d = '0;
    if (sync_lvl != ref_q && !edge_acc) begin
      filt_d = filt_q + 4'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset || Set) begin
      filt_q <= '0;
    end else begin
      filt_q <= filt_d;
    end
  end
`else
  assign edge_acc = (sync_lvl != ref_q);
`endif

  assign pop = Ev_valid & Ev_ready;

  always_comb begin
    ref_d   = ref_q;
    cnt_d   = cnt_q;
    ovf_set = 1'b0;
    if (edge_acc) begin
      ref_d = sync_lvl;
    end
    // A coincident edge and pop cancel, so a full counter cannot overflow then.
    if (edge_acc && !pop) begin
      if (cnt_q == CNT_MAX) begin
        ovf_set = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (!edge_acc && pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (Overflow_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      sync_q <= '0;
      ref_q  <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else if (Set) begin
      // Realign to level 1; any in-flight change is absorbed without an event.
      sync_q <= '1;
      ref_q  <= 1'b1;
    end else begin
      sync_q <= sync_d;
      ref_q  <= ref_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign Ev_valid  = (cnt_q != '0);
  assign Ev_count  = cnt_q;
  assign Level_out = ref_q;
  assign Overflow  = ovf_q;

endmodule

// File: tb/tb_toggle_event_decoder.sv
module tb_toggle_event_decoder;

  localparam int SYNC_STAGES   = 2;
  localparam int CNT_W         = 3;
  localparam int FILTER_CYCLES = 3;
`ifdef TOGGLE_DEC_FILTER_EN
  localparam int LAT        = SYNC_STAGES + FILTER_CYCLES + 1;
  localparam int GLITCH_EXP = 0;
`else
  localparam int LAT        = SYNC_STAGES + 1;
  localparam int GLITCH_EXP = 2;
`endif
  localparam int SPACE = LAT + 1;

  logic             Clock = 1'b0;
  logic             Reset;
  logic             Set;
  logic             Toggle_in;
  logic             Ev_ready;
  logic             Ev_valid;
  logic [CNT_W-1:0] Ev_count;
  logic             Level_out;
  logic             Overflow;
  logic             Overflow_clr;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  always #5 Clock = ~Clock;

  toggle_event_decoder #(
    .SYNC_STAGES  (SYNC_STAGES),
    .CNT_W        (CNT_W),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Set         (Set),
    .Toggle_in   (Toggle_in),
    .Ev_ready    (Ev_ready),
    .Ev_valid    (Ev_valid),
    .Ev_count    (Ev_count),
    .Level_out   (Level_out),
    .Overflow    (Overflow),
    .Overflow_clr(Overflow_clr)
  );

  // Advance n rising edges; return 1 time unit after the last one so that
  // outputs are sampled and inputs driven away from the active edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int v, input int c,
                           input int l, input int o);
    check({tag, ".valid"}, int'(Ev_valid), v);
    check({tag, ".count"}, int'(Ev_count), c);
    check({tag, ".level"}, int'(Level_out), l);
    check({tag, ".ovf"},   int'(Overflow), o);
  endtask

  initial begin
    Reset = 1'b0; Set = 1'b0; Toggle_in = 1'b1;
    Ev_ready = 1'b0; Overflow_clr = 1'b0;

    // 1. Reset with Toggle_in high, then recovery of the pending change.
    tick(2);
    check_all("reset", 0, 0, 0, 0);
    Reset = 1'b1;
    for (int i = 1; i < LAT; i++) begin
      tick(1);
      check("pre_lat_count", int'(Ev_count), 0);
    end
    tick(1);
    check_all("first_event", 1, 1, 1, 0);

    // 2. A 1->0 change is an event too.
    Toggle_in = 1'b0;
    tick(LAT - 1);
    check("fall_pre", int'(Ev_count), 1);
    tick(1);
    check_all("fall_event", 1, 2, 0, 0);

    // 4a. Drain two events, then ready with nothing pending is ignored.
    Ev_ready = 1'b1;
    tick(1);
    check("drain1", int'(Ev_count), 1);
    tick(1);
    check("drain2", int'(Ev_count), 0);
    check("drain2_valid", int'(Ev_valid), 0);
    tick(2);
    check("no_underflow", int'(Ev_count), 0);
    Ev_ready = 1'b0;

    // 3. Saturate the counter and exercise the sticky overflow flag.
    for (int k = 1; k <= 7; k++) begin
      Toggle_in = ~Toggle_in;
      tick(SPACE);
      check("fill_count", int'(Ev_count), k);
    end
    check("fill_no_ovf", int'(Overflow), 0);
    Toggle_in = ~Toggle_in;
    tick(SPACE);
    check_all("ovf_8th", 1, 7, 0, 1);
    Overflow_clr = 1'b1;
    tick(1);
    Overflow_clr = 1'b0;
    check("ovf_clr", int'(Overflow), 0);
    Toggle_in = ~Toggle_in;
    tick(LAT - 1);
    Overflow_clr = 1'b1;
    tick(1);
    Overflow_clr = 1'b0;
    check("ovf_set_wins", int'(Overflow), 1);
    check("ovf_9th_level", int'(Level_out), 1);
    tick(1);
    check("ovf_sticky", int'(Overflow), 1);
    Overflow_clr = 1'b1;
    tick(1);
    Overflow_clr = 1'b0;
    check("ovf_clr2", int'(Overflow), 0);

    // 4b. Edge and pop in the same cycle at full count.
    Toggle_in = ~Toggle_in;
    tick(LAT - 1);
    Ev_ready = 1'b1;
    tick(1);
    Ev_ready = 1'b0;
    check_all("edge_pop_full", 1, 7, 0, 0);

    // 5. Set realigns to level 1 with no event; Reset beats Set.
    Toggle_in = 1'b1;
    Set = 1'b1;
    tick(1);
    Set = 1'b0;
    check_all("set", 1, 7, 1, 0);
    tick(SPACE);
    check("set_no_event", int'(Ev_count), 7);
    Reset = 1'b0;
    Set = 1'b1;
    tick(1);
    check_all("reset_over_set", 0, 0, 0, 0);
    Reset = 1'b1;
    Set = 1'b0;
    tick(SPACE);
    check_all("post_reset_event", 1, 1, 1, 0);
    Ev_ready = 1'b1;
    tick(1);
    Ev_ready = 1'b0;
    check("post_reset_drain", int'(Ev_count), 0);

    // 6. Two-cycle glitch 1->0->1.
    Toggle_in = 1'b0;
    tick(2);
    Toggle_in = 1'b1;
    tick(LAT + 6);
    check("glitch_count", int'(Ev_count), GLITCH_EXP);
    check("glitch_level", int'(Level_out), 1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/toggle_event_decoder.md
Name: toggle_event_decoder

Overview:
Receive side of the toggle-encoded event interface. A T-flip-flop-based encoder flips one level line once per event, and this block recovers those events in the Clock domain. Per block: synchronizes the line, detects each level change, and queues one event per change in a pending counter. A consumer drains the counter one event at a time through a valid/ready handshake.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on Toggle_in (legal range 2 to 4)
CNT_W, 3, pending-event counter width; capacity is 2^CNT_W-1 events
FILTER_CYCLES, 3, stability window in cycles; used only when TOGGLE_DEC_FILTER_EN is defined (legal range 1 to 15)

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  synchronous, active-low reset
Set  input  1  synchronous, active-high; aligns the receiver to encoder level 1
Toggle_in  input  1  toggle line from the encoder; asynchronous to Clock
Ev_ready  input  1  consumer accepts one event this cycle
Ev_valid  output  1  at least one event is pending
Ev_count  output  CNT_W  number of pending events
Level_out  output  1  last accepted (reference) level
Overflow  output  1  sticky flag: an event was dropped
Overflow_clr  input  1  clears Overflow

Behaviour:
- Priority: Reset low > Set > normal operation.
- Reset (Reset=0 at a rising edge):
  - synchronizer chain, ref level, pending counter and Overflow all cleared to 0.
  - Outputs after reset: Ev_valid=0, Ev_count=0, Level_out=0, Overflow=0.
- Set (Set=1, Reset=1):
  - synchronizer chain and ref level forced to 1.
  - pending counter and Overflow unchanged.
  - no event is generated in a Set cycle, even if a change was in flight.
- Synchronizer:
  - s[0] <= Toggle_in; s[k] <= s[k-1].
  - sync_lvl = s[SYNC_STAGES-1].
- Edge detect:
  - edge = (sync_lvl != ref).
  - On edge: ref <= sync_lvl, and exactly one event is counted.
  - Both 0->1 and 1->0 transitions count as events.
- Pop condition: pop = Ev_valid & Ev_ready.
- Pending counter update, per cycle:
  - edge only: +1 if count < max; if count == max, count holds and Overflow <= 1.
  - pop only: -1.
  - edge and pop together: count unchanged; no overflow, even at max.
  - neither: hold.
- Ev_valid = (count != 0). It is registered-equivalent: no combinational path from Toggle_in or Ev_ready.
- Ev_ready while Ev_valid=0: ignored; the count never underflows.
- Overflow_clr:
  - clears Overflow.
  - if an overflow occurs in the same cycle, Overflow stays 1 (set wins).
- Latency:
  - Toggle_in change (meeting setup before edge 1) -> Ev_count increments on edge SYNC_STAGES+1.
  - Ev_valid is visible after that edge.
- Back-to-back toggles: each toggle must hold for at least SYNC_STAGES+1 cycles. Faster toggling may be merged and lose events; this is the encoder's obligation and is not detected.
- Reset mid-operation: all pending events are discarded, and Level_out returns to 0 regardless of Toggle_in.

Optional Feature:
TOGGLE_DEC_FILTER_EN
- Defined:
  - a filter counter increments while sync_lvl != ref and clears when they are equal.
  - edge is accepted only when the filter counter reaches FILTER_CYCLES; the filter counter then clears.
  - a level that reverts earlier produces no event.
  - latency becomes SYNC_STAGES+FILTER_CYCLES+1.
  - Reset and Set also clear the filter counter.
- Not defined:
  - no filter logic is present.
  - edge is accepted immediately, as described above.

Test Plan:
1. Reset=0 for 2 cycles with Toggle_in=1 -> after release, Ev_valid=0, Ev_count=0, Level_out=0, Overflow=0; Ev_count=1 on edge 3 after release (SYNC_STAGES=2).
2. Toggle_in 0->1 before edge 1, Ev_ready=0 -> Ev_count=1, Ev_valid=1, Level_out=1 after edge 3, with no change before it.
3. 9 toggles spaced 4 cycles, Ev_ready=0, CNT_W=3:
   - Ev_count saturates at 7.
   - Overflow=1 after the 8th event.
   - Overflow_clr=1 for one cycle -> Overflow=0.
   - Overflow_clr coincident with a 9th overflow -> Overflow stays 1.
4. Drain and simultaneous edge/pop:
   - Ev_count=2, Ev_ready=1 held -> Ev_count goes 1 then 0; Ev_valid=0 after the 2nd pop; further Ev_ready is ignored and the count stays 0.
   - Ev_count=7 with an edge and a pop in the same cycle -> count stays 7 and Overflow does not set.
5. Set=1 with Toggle_in=1 and ref=0 -> Level_out=1 and no event. Reset=0 and Set=1 together -> reset values win.
6. 2-cycle glitch on Toggle_in (0->1->0):
   - with TOGGLE_DEC_FILTER_EN and FILTER_CYCLES=3 -> no event.
   - without the macro -> Ev_count=2.
